// File: rtl/truth_table_sweeper.sv
// Drives every input combination of a small combinational block, waits SETTLE cycles,
// samples its output and assembles the truth table. Optional comparator: TT_COMPARE_EN.
module truth_table_sweeper #(
  parameter  int N_IN   = 3,
  parameter  int SETTLE = 2,
  localparam int TT_W   = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            tt_valid,
  output logic [TT_W-1:0] truth_table
`ifdef TT_COMPARE_EN
  ,
  input  logic [TT_W-1:0] expected_tt,
  output logic            mismatch
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            tt_valid_q, tt_valid_d;
  logic [TT_W-1:0] tt_q, tt_d;
`ifdef TT_COMPARE_EN
  logic            mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d    = state_q;
    dut_in_d   = dut_in_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    tt_valid_d = tt_valid_q;
    tt_d       = tt_q;
`ifdef TT_COMPARE_EN
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dut_in_d   = '0;
          tt_d       = '0;
          tt_valid_d = 1'b0;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
`ifdef TT_COMPARE_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_SAMPLE: begin
        tt_d[dut_in_q] = dut_out;
        // Last combination: hold dut_in at all-ones rather than wrapping.
        if (&dut_in_q) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          dut_in_d = dut_in_q + N_IN'(1);
          cnt_d    = CNT_LOAD;
          state_d  = S_SETTLE;
        end
      end
      default: begin
        tt_valid_d = 1'b1;
`ifdef TT_COMPARE_EN
        mismatch_d = (tt_q != expected_tt);
`endif
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dut_in_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      tt_valid_q <= 1'b0;
      tt_q       <= '0;
`ifdef TT_COMPARE_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dut_in_q   <= dut_in_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      tt_valid_q <= tt_valid_d;
      tt_q       <= tt_d;
`ifdef TT_COMPARE_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign dut_in      = dut_in_q;
  assign busy        = busy_q;
  assign done        = (state_q == S_DONE);
  assign tt_valid    = tt_valid_q;
  assign truth_table = tt_q;
`ifdef TT_COMPARE_EN
  assign mismatch    = mismatch_q;
`endif

endmodule
